// File: rtl/debug_pkg.sv
// debug_pkg: opcode, harness command and FSM state encodings shared by the debug host controller.
// Revision: 1.0
`default_nettype none

package debug_pkg;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_RUN   = 8'h02;
  localparam logic [7:0] OP_STEPI = 8'h03;
  localparam logic [7:0] OP_STEPC = 8'h04;
  localparam logic [7:0] OP_CLEAR = 8'h05;

  localparam logic [3:0] CMD_IDLE  = 4'd0;
  localparam logic [3:0] CMD_RUN   = 4'd1;
  localparam logic [3:0] CMD_STEPI = 4'd2;
  localparam logic [3:0] CMD_STEPC = 4'd3;

  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_LEN_HI    = 4'd1;
  localparam state_t ST_LEN_LO    = 4'd2;
  localparam state_t ST_LOAD_DATA = 4'd3;
  localparam state_t ST_ISSUE     = 4'd4;
  localparam state_t ST_WAIT      = 4'd5;
  localparam state_t ST_CLEAR     = 4'd6;
  localparam state_t ST_STATUS    = 4'd7;
  localparam state_t ST_DUMP      = 4'd8;

  localparam logic [3:0] STATUS_TAG    = 4'hA;
  localparam logic [7:0] STATUS_BAD_OP = 8'hAF;

  function automatic logic [7:0] status_byte(input logic ovf, input logic tmo, input logic ext);
    return {STATUS_TAG, 1'b0, ovf, tmo, ext};
  endfunction

  function automatic logic [3:0] op_to_cmd(input logic [7:0] op);
    case (op)
      OP_RUN:   return CMD_RUN;
      OP_STEPI: return CMD_STEPI;
      OP_STEPC: return CMD_STEPC;
      default:  return CMD_IDLE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbg_dump_serializer.sv
// dbg_dump_serializer: snapshots the harness register file and streams it MSB-first, reg 0 first.
// Revision: 1.0
`default_nettype none

module dbg_dump_serializer #(
  parameter int DUMP_REGS = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_capture,
  input  logic [DUMP_REGS*32-1:0] i_reg_dump,
  input  logic                    i_start,
  input  logic                    i_tx_ready,
  output logic                    o_tx_valid,
  output logic [7:0]              o_tx_data,
  output logic                    o_done
);

  localparam int NBYTES = DUMP_REGS * 4;
  localparam int IW     = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  logic [DUMP_REGS*32-1:0] r_snap;
  logic [IW-1:0]           r_idx;
  logic                    r_busy;
  logic [IW+2:0]           w_bit_off;

  // Byte k of the dump is reg k/4, byte (3 - k%4) counted from the LSB.
  assign w_bit_off  = {r_idx[IW-1:2], ~r_idx[1:0], 3'b000};
  assign o_tx_data  = r_snap[w_bit_off +: 8];
  assign o_tx_valid = r_busy;
  assign o_done     = r_busy && i_tx_ready && (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= '0;
      r_idx  <= '0;
      r_busy <= 1'b0;
    end else begin
      if (i_capture) begin
        r_snap <= i_reg_dump;
      end
      if (i_start) begin
        r_busy <= 1'b1;
        r_idx  <= '0;
      end else if (r_busy && i_tx_ready) begin
        if (r_idx == LAST_IDX) begin
          r_busy <= 1'b0;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/debug_host_ctrl.sv
// debug_host_ctrl: host byte-protocol initiator that loads code ROM, issues debug commands and returns status + dump.
// Optional watchdog on command completion enabled by DEBUG_HOST_TIMEOUT_EN. Revision: 1.0
`default_nettype none

module debug_host_ctrl
  import debug_pkg::*;
#(
  parameter int CODE_BYTES = 516,
  parameter int DUMP_REGS  = 32
`ifdef DEBUG_HOST_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic [7:0]              rx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic [3:0]              debug_cmd,
  output logic                    program_rom_mode,
  output logic [11:0]             code_rom_addr_in,
  output logic [7:0]              code_rom_data_in,
  output logic                    reset_code_rom_n,
  input  logic                    command_complete,
  input  logic                    exit_signal,
  input  logic [DUMP_REGS*32-1:0] reg_dump
);

  localparam logic [15:0] CODE_LIM = 16'(CODE_BYTES);

  state_t      r_state;
  logic        r_live;
  logic        r_is_exec;
  logic        r_ovf;
  logic [7:0]  r_len_hi;
  logic [15:0] r_remaining;
  logic [15:0] r_addr_cnt;
  logic [3:0]  r_debug_cmd;
  logic        r_prog;
  logic [11:0] r_addr;
  logic [7:0]  r_data;
  logic        r_rom_rst_n;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;

  logic        w_rx_fire;
  logic        w_in_range;
  logic        w_timeout_hit;
  logic        w_capture;
  logic        w_ser_start;
  logic        w_ser_done;
  logic        w_ser_valid;
  logic [7:0]  w_ser_data;
  logic [15:0] w_len;

  // r_live keeps rx_ready low in the reset cycle even though the state is already IDLE.
  assign rx_ready = r_live && ((r_state == ST_IDLE) || (r_state == ST_LEN_HI) ||
                               (r_state == ST_LEN_LO) || (r_state == ST_LOAD_DATA));

  assign w_rx_fire   = rx_valid && rx_ready;
  assign w_in_range  = (r_addr_cnt < CODE_LIM);
  assign w_len       = {r_len_hi, rx_data};
  assign w_capture   = (r_state == ST_WAIT) && (command_complete || w_timeout_hit);
  assign w_ser_start = (r_state == ST_STATUS) && tx_ready && r_is_exec;

  assign tx_valid         = (r_state == ST_DUMP) ? w_ser_valid : r_tx_valid;
  assign tx_data          = (r_state == ST_DUMP) ? w_ser_data  : r_tx_data;
  assign debug_cmd        = r_debug_cmd;
  assign program_rom_mode = r_prog;
  assign code_rom_addr_in = r_addr;
  assign code_rom_data_in = r_data;
  assign reset_code_rom_n = r_rom_rst_n;

`ifdef DEBUG_HOST_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + TW'(1);
    end
  end

  assign w_timeout_hit = (r_state == ST_WAIT) && !command_complete &&
                         (r_wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_live      <= 1'b0;
      r_is_exec   <= 1'b0;
      r_ovf       <= 1'b0;
      r_len_hi    <= 8'h00;
      r_remaining <= 16'h0000;
      r_addr_cnt  <= 16'h0000;
      r_debug_cmd <= CMD_IDLE;
      r_prog      <= 1'b0;
      r_addr      <= 12'h000;
      r_data      <= 8'h00;
      r_rom_rst_n <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_live      <= 1'b1;
      r_prog      <= 1'b0;
      r_rom_rst_n <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_rx_fire) begin
            r_ovf     <= 1'b0;
            r_is_exec <= 1'b0;
            case (rx_data)
              OP_LOAD: r_state <= ST_LEN_HI;
              OP_RUN, OP_STEPI, OP_STEPC: begin
                r_is_exec   <= 1'b1;
                r_debug_cmd <= op_to_cmd(rx_data);
                r_state     <= ST_ISSUE;
              end
              OP_CLEAR: begin
                r_rom_rst_n <= 1'b0;
                r_state     <= ST_CLEAR;
              end
              default: begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= STATUS_BAD_OP;
                r_state    <= ST_STATUS;
              end
            endcase
          end
        end
        ST_LEN_HI: begin
          if (w_rx_fire) begin
            r_len_hi <= rx_data;
            r_state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (w_rx_fire) begin
            r_addr_cnt  <= 16'h0000;
            r_remaining <= w_len;
            if (w_len == 16'h0000) begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= status_byte(r_ovf, 1'b0, exit_signal);
              r_state    <= ST_STATUS;
            end else begin
              r_state <= ST_LOAD_DATA;
            end
          end
        end
        ST_LOAD_DATA: begin
          if (w_rx_fire) begin
            // Bytes beyond the ROM are swallowed so the host stream stays in sync.
            if (w_in_range) begin
              r_prog <= 1'b1;
              r_addr <= r_addr_cnt[11:0];
              r_data <= rx_data;
            end else begin
              r_ovf <= 1'b1;
            end
            r_addr_cnt  <= r_addr_cnt + 16'd1;
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= status_byte(r_ovf | ~w_in_range, 1'b0, exit_signal);
              r_state    <= ST_STATUS;
            end
          end
        end
        ST_ISSUE: begin
          r_debug_cmd <= CMD_IDLE;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_capture) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= status_byte(r_ovf, w_timeout_hit, exit_signal);
            r_state    <= ST_STATUS;
          end
        end
        ST_CLEAR: begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= status_byte(r_ovf, 1'b0, exit_signal);
          r_state    <= ST_STATUS;
        end
        ST_STATUS: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= r_is_exec ? ST_DUMP : ST_IDLE;
          end
        end
        ST_DUMP: begin
          if (w_ser_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dbg_dump_serializer #(
    .DUMP_REGS(DUMP_REGS)
  ) u_dump (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_capture  (w_capture),
    .i_reg_dump (reg_dump),
    .i_start    (w_ser_start),
    .i_tx_ready (tx_ready),
    .o_tx_valid (w_ser_valid),
    .o_tx_data  (w_ser_data),
    .o_done     (w_ser_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_debug_host_ctrl.sv
// tb_debug_host_ctrl: randomized host/harness stimulus against a protocol-level reference model.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_debug_host_ctrl;

  localparam int CODE_BYTES = 516;
  localparam int DUMP_REGS  = 32;
  localparam int NBYTES     = DUMP_REGS * 4;
  localparam int TMO        = 16;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    rx_valid = 1'b0;
  logic                    rx_ready;
  logic [7:0]              rx_data = 8'h00;
  logic                    tx_valid;
  logic                    tx_ready = 1'b0;
  logic [7:0]              tx_data;
  logic [3:0]              debug_cmd;
  logic                    program_rom_mode;
  logic [11:0]             code_rom_addr_in;
  logic [7:0]              code_rom_data_in;
  logic                    reset_code_rom_n;
  logic                    command_complete = 1'b0;
  logic                    exit_signal = 1'b0;
  logic [DUMP_REGS*32-1:0] reg_dump;

  logic [31:0] tb_regs  [DUMP_REGS];
  logic [31:0] exp_regs [DUMP_REGS];
  logic [7:0]  ld       [1024];
  logic [11:0] wr_addr  [1024];
  logic [7:0]  wr_data  [1024];
  int          wr_n       = 0;
  int          cmd_cycles = 0;
  int          clr_cycles = 0;
  int          rdy_pct    = 100;
  int          checks     = 0;
  int          failures   = 0;

  always #5 clk = ~clk;

  always_comb begin
    reg_dump = '0;
    for (int i = 0; i < DUMP_REGS; i++) reg_dump[32*i +: 32] = tb_regs[i];
  end

  debug_host_ctrl #(
    .CODE_BYTES(CODE_BYTES),
    .DUMP_REGS (DUMP_REGS)
`ifdef DEBUG_HOST_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .rx_data          (rx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_data          (tx_data),
    .debug_cmd        (debug_cmd),
    .program_rom_mode (program_rom_mode),
    .code_rom_addr_in (code_rom_addr_in),
    .code_rom_data_in (code_rom_data_in),
    .reset_code_rom_n (reset_code_rom_n),
    .command_complete (command_complete),
    .exit_signal      (exit_signal),
    .reg_dump         (reg_dump)
  );

  // Harness-side observers: ROM write log, command pulse and ROM clear cycle counts.
  always @(negedge clk) begin
    if (program_rom_mode) begin
      wr_addr[wr_n % 1024] <= code_rom_addr_in;
      wr_data[wr_n % 1024] <= code_rom_data_in;
      wr_n <= wr_n + 1;
    end
    if (debug_cmd != 4'd0) cmd_cycles <= cmd_cycles + 1;
    if (reset_n && !reset_code_rom_n) clr_cycles <= clr_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string w);
    chk({w, "_rx_ready"}, rx_ready, 0);
    chk({w, "_tx_valid"}, tx_valid, 0);
    chk({w, "_tx_data"}, tx_data, 0);
    chk({w, "_debug_cmd"}, debug_cmd, 0);
    chk({w, "_prog"}, program_rom_mode, 0);
    chk({w, "_addr"}, code_rom_addr_in, 0);
    chk({w, "_data"}, code_rom_data_in, 0);
    chk({w, "_rom_rst_n"}, reset_code_rom_n, 0);
  endtask

  task automatic rand_regs(input logic [31:0] r1);
    for (int i = 0; i < DUMP_REGS; i++) tb_regs[i] = $urandom;
    tb_regs[1] = r1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", rx_ready, 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int         n;
    logic       pend;
    logic       got;
    logic [7:0] pd;
    n = 0; pend = 1'b0; got = 1'b0; pd = 8'h00; b = 8'h00;
    while (!got && n < 2000) begin
      @(negedge clk);
      if (pend) chk("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, pd});
      tx_ready = ($urandom_range(0, 99) < rdy_pct);
      if (tx_valid && tx_ready) begin
        b   = tx_data;
        got = 1'b1;
      end else if (tx_valid) begin
        pend = 1'b1;
        pd   = tx_data;
      end
      n++;
    end
    chk("tx_arrive", got, 1);
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask

  task automatic run_load(input int len);
    logic [7:0] b;
    int         w0;
    int         nw;
    w0 = wr_n;
    send_byte(8'h01);
    send_byte(8'(len >> 8));
    send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(ld[i]);
    recv_byte(b);
    chk("load_status", b, (len > CODE_BYTES) ? 8'hA4 : 8'hA0);
    @(negedge clk);
    nw = (len < CODE_BYTES) ? len : CODE_BYTES;
    chk("load_count", wr_n - w0, nw);
    for (int k = 0; k < nw; k++) begin
      chk("load_addr", wr_addr[(w0 + k) % 1024], k);
      chk("load_data", wr_data[(w0 + k) % 1024], ld[k]);
    end
    chk("prog_idle", program_rom_mode, 0);
  endtask

  task automatic run_clear();
    logic [7:0] b;
    int         c0;
    c0 = clr_cycles;
    send_byte(8'h05);
    recv_byte(b);
    chk("clear_status", b, 8'hA0);
    @(negedge clk);
    chk("clear_pulse", clr_cycles - c0, 1);
  endtask

  task automatic run_bad(input logic [7:0] op);
    logic [7:0] b;
    int         c0;
    int         cnt;
    c0 = cmd_cycles;
    cnt = 0;
    send_byte(op);
    recv_byte(b);
    chk("bad_status", b, 8'hAF);
    tx_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (tx_valid) cnt++;
    end
    tx_ready = 1'b0;
    chk("bad_no_dump", cnt, 0);
    chk("bad_no_cmd", cmd_cycles - c0, 0);
    chk("bad_rx_ready", rx_ready, 1);
  endtask

  // dly < 0: harness never completes; abort_at >= 0: reset asserted before that dump byte.
  task automatic run_exec(input logic [7:0] op, input int dly, input logic ex,
                          input logic [31:0] r1, input logic early, input int abort_at);
    logic [7:0] b;
    logic [7:0] st;
    int         c0;
    int         n;
    exit_signal = 1'b0;
    rand_regs(r1);
    c0 = cmd_cycles;
    send_byte(op);
    n = 0;
    @(negedge clk);
    while (debug_cmd == 4'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_code", debug_cmd, 32'(op) - 1);
    if (dly >= 0) begin
      command_complete = early;
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        command_complete = 1'b0;
      end
      rand_regs(r1);
      exit_signal      = ex;
      command_complete = 1'b1;
      for (int i = 0; i < DUMP_REGS; i++) exp_regs[i] = tb_regs[i];
      @(negedge clk);
      command_complete = 1'b0;
      rand_regs(r1);
      st = {4'hA, 3'b000, ex};
    end else begin
      for (int i = 0; i < DUMP_REGS; i++) exp_regs[i] = tb_regs[i];
      st = 8'hA2;
    end
    recv_byte(b);
    chk("status", b, st);
    for (int k = 0; k < NBYTES; k++) begin
      if (k == abort_at) begin
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exit_signal = 1'b0;
        return;
      end
      recv_byte(b);
      chk($sformatf("dump[%0d]", k), b, 8'(exp_regs[k / 4] >> (24 - 8 * (k % 4))));
    end
    @(negedge clk);
    chk("dump_end", tx_valid, 0);
    chk("cmd_pulses", cmd_cycles - c0, 1);
    exit_signal = 1'b0;
  endtask

  initial begin
    int n;
    rand_regs(32'h0);
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("live_rx_ready", rx_ready, 1);
    chk("live_rom_rst_n", reset_code_rom_n, 1);

    ld[0] = 8'h13; ld[1] = 8'h05; ld[2] = 8'h10; ld[3] = 8'h00;
    run_load(4);
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) ld[i] = 8'($urandom);
      run_load(n);
    end
    run_load(0);
    for (int i = 0; i < CODE_BYTES + 2; i++) ld[i] = 8'($urandom);
    run_load(CODE_BYTES + 2);
    run_clear();

    rdy_pct = 100; run_exec(8'h03, 7, 1'b0, 32'h12345678, 1'b0, -1);
    rdy_pct = 50;  run_exec(8'h02, 5, 1'b1, $urandom, 1'b0, -1);
    rdy_pct = 60;  run_exec(8'h04, 4, 1'b1, $urandom, 1'b1, -1);
    for (int t = 0; t < 5; t++) begin
      rdy_pct = $urandom_range(30, 100);
      run_exec(8'($urandom_range(2, 4)), $urandom_range(1, 12), 1'($urandom), $urandom,
               1'($urandom), -1);
    end

    run_bad(8'h7E);
    run_bad(8'h00);

`ifdef DEBUG_HOST_TIMEOUT_EN
    rdy_pct = 70; run_exec(8'h03, -1, 1'b0, $urandom, 1'b0, -1);
`endif

    rdy_pct = 80;  run_exec(8'h04, 4, 1'b0, $urandom, 1'b0, 40);
    @(negedge clk);
    chk("post_abort_rx_ready", rx_ready, 1);
    rdy_pct = 100; run_exec(8'h04, 6, 1'b0, $urandom, 1'b0, -1);
    ld[0] = 8'hA5; ld[1] = 8'h5A;
    run_load(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
